rtc_mux_bus_master: RTL and testbench

- Parametrised master for the RTC multiplexed address/data bus. Successor to the single-access RTC protocol block.
- Executes single or burst read/write commands: one address phase, then one data phase per word.
- Phase timing is programmable via parameters.
- Sits between the time/date/chronometer control FSM (command side) and the top-level pad wrapper, which owns the bidirectional AD buffer.

---
 rtl/rtc_bus_pkg.sv | 24 ++
 rtl/rtc_phase_timer.sv | 22 ++
 rtl/rtc_mux_bus_master.sv | 167 ++++++++++++++++
 tb/tb_rtc_mux_bus_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC multiplexed-bus master: FSM states, phase-length
// selector and timing helpers.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_A_SU, S_A_STB, S_A_HLD, S_D_SU, S_D_STB, S_D_HLD, S_GAP
  } state_e;

  typedef enum logic [1:0] {PH_SU, PH_STB, PH_HLD, PH_GAP} phase_e;

  function automatic int word_period(int su, int stb, int hld, int gap);
    return 2 * (su + stb + hld) + gap;
  endfunction

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; last is high in the final cycle of a phase.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rtc_mux_bus_master.sv
// Burst read/write master for the RTC multiplexed AD bus: per word one
// address phase, one data phase and a chip-select gap.
module rtc_mux_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4,
  parameter int T_SU   = 2,
  parameter int T_STB  = 4,
  parameter int T_HLD  = 2,
  parameter int T_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              wr_pull,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [LEN_W-1:0]  rd_index,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              a_d,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam int TMAX = max4(T_SU, T_STB, T_HLD, T_GAP);
  localparam int TW   = $clog2(TMAX) + 1;

  state_e            state, nstate;
  phase_e            ph;
  logic              load, last;
  logic [TW-1:0]     load_val;

  logic              write_q, abort_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, word_q;
  logic [DATA_W-1:0] wdata_q, addr_ext;
  logic              accept, more, stop, addr_ph, data_ph;

  assign accept = cmd_valid & cmd_ready;
  assign more   = (word_q != len_q);
  // An abort arriving in the very cycle of the word-boundary decision counts.
  assign stop   = abort_q | abort;

  always_comb begin
    case (ph)
      PH_SU:   load_val = TW'(T_SU - 1);
      PH_STB:  load_val = TW'(T_STB - 1);
      PH_HLD:  load_val = TW'(T_HLD - 1);
      default: load_val = TW'(T_GAP - 1);
    endcase
  end

  rtc_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    load   = 1'b0;
    ph     = PH_SU;
    case (state)
      S_IDLE:  if (cmd_valid) begin nstate = S_A_SU;  load = 1'b1; ph = PH_SU;  end
      S_A_SU:  if (last)      begin nstate = S_A_STB; load = 1'b1; ph = PH_STB; end
      S_A_STB: if (last)      begin nstate = S_A_HLD; load = 1'b1; ph = PH_HLD; end
      S_A_HLD: if (last)      begin nstate = S_D_SU;  load = 1'b1; ph = PH_SU;  end
      S_D_SU:  if (last)      begin nstate = S_D_STB; load = 1'b1; ph = PH_STB; end
      S_D_STB: if (last)      begin nstate = S_D_HLD; load = 1'b1; ph = PH_HLD; end
      S_D_HLD: if (last)      begin nstate = S_GAP;   load = 1'b1; ph = PH_GAP; end
      S_GAP: begin
        if (last) begin
          if (more && !stop) begin nstate = S_A_SU; load = 1'b1; ph = PH_SU; end
          else                     nstate = S_IDLE;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  generate
    if (ADDR_W >= DATA_W) begin : g_trunc
      assign addr_ext = addr_q[DATA_W-1:0];
    end else begin : g_zext
      assign addr_ext = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
    end
  endgenerate

  assign addr_ph   = (state == S_A_SU) || (state == S_A_STB) || (state == S_A_HLD);
  assign data_ph   = (state == S_D_SU) || (state == S_D_STB) || (state == S_D_HLD);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign cs_n      = !(addr_ph || data_ph);
  assign a_d       = data_ph;
  assign ad_oe     = addr_ph || (data_ph && write_q);
  assign ad_out    = addr_ph ? addr_ext : ((data_ph && write_q) ? wdata_q : '0);
  // The address is always latched with the write strobe, even for reads.
  assign wr_n      = !((state == S_A_STB) || (state == S_D_STB && write_q));
  assign rd_n      = !(state == S_D_STB && !write_q);
  assign wr_pull   = (state == S_A_HLD) && last && write_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_index <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        len_q   <= cmd_len;
        word_q  <= '0;
        abort_q <= 1'b0;
      end else if (state != S_IDLE && abort) begin
        abort_q <= 1'b1;
      end
      if (wr_pull) wdata_q <= wr_data;
      if (state == S_D_STB && last && !write_q) begin
        rd_valid <= 1'b1;
        rd_data  <= ad_in;
        rd_index <= word_q;
      end
      if (state == S_GAP && last) begin
        if (more && !stop) begin
          addr_q <= addr_q + 1'b1;
          word_q <= word_q + 1'b1;
        end else begin
          done    <= 1'b1;
          aborted <= more && stop;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Directed bench for rtc_mux_bus_master at default timing (word period 20).
module tb_rtc_mux_bus_master;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       abort, wr_pull;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid;
  logic [3:0] rd_index;
  logic       busy, done, aborted, cs_n, wr_n, rd_n, a_d, ad_oe;
  logic [7:0] ad_out, ad_in;

  int total = 0;
  int bad   = 0;

  rtc_mux_bus_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
    .wr_pull(wr_pull), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_index(rd_index), .busy(busy), .done(done), .aborted(aborted), .cs_n(cs_n),
    .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Position within a 20-cycle word, 1..20.
  function automatic int pos(int c);
    return ((c - 1) % 20) + 1;
  endfunction

  task automatic start_cmd(input logic w, input logic [7:0] a, input logic [3:0] l);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({cs_n, wr_n, rd_n, a_d, ad_oe, busy, done, rd_valid, wr_pull, aborted, cmd_ready} !== 11'b11100000001) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=11100000001",
               {cs_n, wr_n, rd_n, a_d, ad_oe, busy, done, rd_valid, wr_pull, aborted, cmd_ready});
    end
    total++;
    if ({ad_out, rd_data, rd_index} !== 20'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=00000", {ad_out, rd_data, rd_index});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] exp_ctl, exp_ad;
    wr_data = 8'h0F;
    start_cmd(1'b1, 8'h0A, 4'd0);
    for (int c = 1; c <= 24; c++) begin
      exp_ctl = {!(c >= 1 && c <= 16), !((c >= 3 && c <= 6) || (c >= 11 && c <= 14)), 1'b1,
                 (c >= 9 && c <= 16), (c >= 1 && c <= 16), (c == 8), (c == 21), (c >= 1 && c <= 20)};
      exp_ad = (c <= 8) ? 8'h0A : (c <= 16) ? 8'h0F : 8'h00;
      total++;
      if ({cs_n, wr_n, rd_n, a_d, ad_oe, wr_pull, done, busy} !== exp_ctl) begin
        bad++;
        $display("FAIL write_ctl c=%0d got=%b exp=%b", c, {cs_n, wr_n, rd_n, a_d, ad_oe, wr_pull, done, busy}, exp_ctl);
      end
      total++;
      if (ad_out !== exp_ad) begin
        bad++;
        $display("FAIL write_ad c=%0d got=%h exp=%h", c, ad_out, exp_ad);
      end
      tick();
    end
  endtask

  task automatic test_read();
    logic [6:0] exp_ctl;
    int p, k;
    logic act;
    start_cmd(1'b0, 8'h21, 4'd2);
    for (int c = 1; c <= 64; c++) begin
      p = pos(c); k = (c - 1) / 20; act = (c <= 60);
      ad_in = 8'(8'h51 + k);
      exp_ctl = {!(act && p <= 16), !(act && p >= 3 && p <= 6), !(act && p >= 11 && p <= 14),
                 (act && p <= 8), (c == 15 || c == 35 || c == 55), (c == 61), 1'b0};
      total++;
      if ({cs_n, wr_n, rd_n, ad_oe, rd_valid, done, wr_pull} !== exp_ctl) begin
        bad++;
        $display("FAIL read_ctl c=%0d got=%b exp=%b", c, {cs_n, wr_n, rd_n, ad_oe, rd_valid, done, wr_pull}, exp_ctl);
      end
      if (act && p <= 8) begin
        total++;
        if (ad_out !== 8'(8'h21 + k)) begin
          bad++;
          $display("FAIL read_addr c=%0d got=%h exp=%h", c, ad_out, 8'(8'h21 + k));
        end
      end
      if (c == 15 || c == 35 || c == 55) begin
        total++;
        if ({rd_data, rd_index} !== {8'(8'h51 + k), 4'(k)}) begin
          bad++;
          $display("FAIL read_data c=%0d got=%h/%0d exp=%h/%0d", c, rd_data, rd_index, 8'(8'h51 + k), k);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    start_cmd(1'b0, 8'hFF, 4'd1);
    for (int c = 1; c <= 42; c++) begin
      ad_in = 8'h77;
      if (c == 5 || c == 25) begin
        total++;
        if (ad_out !== ((c == 5) ? 8'hFF : 8'h00)) begin
          bad++;
          $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, ad_out, (c == 5) ? 8'hFF : 8'h00);
        end
      end
      total++;
      if ({done, aborted} !== {(c == 41), 1'b0}) begin
        bad++;
        $display("FAIL wrap_done c=%0d got=%b exp=%b", c, {done, aborted}, {(c == 41), 1'b0});
      end
      if (c == 35) begin
        total++;
        if ({rd_valid, rd_index, rd_data} !== {1'b1, 4'd1, 8'h77}) begin
          bad++;
          $display("FAIL wrap_rd c=%0d got=%b/%0d/%h exp=1/1/77", c, rd_valid, rd_index, rd_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp_ctl;
    wr_data = 8'h5A;
    start_cmd(1'b1, 8'h40, 4'd3);
    for (int c = 1; c <= 80; c++) begin
      abort = (c == 25);
      exp_ctl = {!(c <= 36 && pos(c) <= 16), (c == 8 || c == 28), (c <= 40), (c == 41), (c == 41)};
      total++;
      if ({cs_n, wr_pull, busy, done, aborted} !== exp_ctl) begin
        bad++;
        $display("FAIL abort_ctl c=%0d got=%b exp=%b", c, {cs_n, wr_pull, busy, done, aborted}, exp_ctl);
      end
      tick();
    end
    abort = 1'b0;
  endtask

  // Abort in IDLE is ignored; abort during the final word is not an early stop.
  task automatic test_abort_edge();
    abort = 1'b1;
    start_cmd(1'b0, 8'h10, 4'd1);
    abort = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      ad_in = 8'h3C;
      abort = (c == 25);
      total++;
      if ({done, aborted, rd_valid} !== {(c == 41), 1'b0, (c == 15 || c == 35)}) begin
        bad++;
        $display("FAIL abort_edge c=%0d got=%b exp=%b", c, {done, aborted, rd_valid}, {(c == 41), 1'b0, (c == 15 || c == 35)});
      end
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_data = 8'h0F;
    start_cmd(1'b1, 8'h0A, 4'd0);
    for (int c = 1; c < 12; c++) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({cs_n, wr_n, ad_oe, busy, cmd_ready} !== 5'b11001) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=11001", {cs_n, wr_n, ad_oe, busy, cmd_ready});
    end
    reset = 1'b0;
    for (int c = 14; c <= 38; c++) begin
      tick();
      total++;
      if ({done, cs_n} !== 2'b01) begin
        bad++;
        $display("FAIL reset_quiet c=%0d got=%b exp=01", c, {done, cs_n});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_ctl;
    wr_data = 8'h0F;
    cmd_write = 1'b1; cmd_addr = 8'h0A; cmd_len = 4'd0; cmd_valid = 1'b1;
    tick();
    for (int c = 1; c <= 44; c++) begin
      if (c == 22) cmd_valid = 1'b0;
      exp_ctl = {(c == 21 || c >= 42), (c == 21 || c == 42),
                 !((c >= 1 && c <= 16) || (c >= 22 && c <= 37)),
                 (c == 8 || c == 29), ((c >= 1 && c <= 20) || (c >= 22 && c <= 41))};
      total++;
      if ({cmd_ready, done, cs_n, wr_pull, busy} !== exp_ctl) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, {cmd_ready, done, cs_n, wr_pull, busy}, exp_ctl);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    abort = 1'b0; wr_data = '0; ad_in = '0;
    test_reset();
    test_write();
    tick();
    test_read();
    tick();
    test_wrap();
    tick();
    test_abort();
    tick();
    test_abort_edge();
    tick();
    test_reset_mid();
    tick();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
